// File: rtl/mips16_pipeline_ctrl.sv
// Pipeline sequencing controller for the mips_16 five-stage core.
// Drives the IF/ID enables and detects RAW hazards against EX/MEM/WB.
// Kills the wrong-path instruction after a taken branch and runs the
// debug halt/single-step handshake. Keeps a saturating stall counter.
module mips16_pipeline_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  dec_src1_i,
   input  logic [2:0]  dec_src2_i,
   input  logic        ex_wb_en_i,
   input  logic        mem_wb_en_i,
   input  logic        wb_wb_en_i,
   input  logic [2:0]  ex_dest_i,
   input  logic [2:0]  mem_dest_i,
   input  logic [2:0]  wb_dest_i,
   input  logic        branch_taken_i,
   input  logic        halt_req_i,
   input  logic        step_req_i,
   input  logic        perf_clr_i,
   output logic        fetch_en_o,
   output logic        decode_en_o,
   output logic        id_kill_o,
   output logic        halted_o,
   output logic [15:0] stall_cycles_o
);

   localparam int unsigned REG_W = 3;
   localparam int unsigned CNT_W = 16;

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] HALTED = 2'd1;
   localparam logic [1:0] STEP   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             kill_q, kill_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             hazard_c;
   logic             run_en_c;

   // Hit test for one stage: register 0 is never a real dependency.
   function automatic logic stage_hit(input logic wb_en, input logic [REG_W-1:0] dest,
                                      input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2);
      return wb_en && (dest != REG_W'(0)) && ((dest == s1) || (dest == s2));
   endfunction

   // RAW hazard between the decode instruction and any in-flight destination.
   always_comb begin
      hazard_c = stage_hit(ex_wb_en_i,  ex_dest_i,  dec_src1_i, dec_src2_i)
               | stage_hit(mem_wb_en_i, mem_dest_i, dec_src1_i, dec_src2_i)
               | stage_hit(wb_wb_en_i,  wb_dest_i,  dec_src1_i, dec_src2_i);
   end

   // State, kill and stall-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         kill_q  <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
         stall_q <= stall_d;
      end
   end

   // Next state and enables; a pending kill overrides hazard and halt.
   always_comb begin
      state_d     = state_q;
      fetch_en_o  = 1'b0;
      decode_en_o = 1'b0;
      halted_o    = 1'b0;
      run_en_c    = !hazard_c && !kill_q;

      case (state_q)
         RUN: begin
            fetch_en_o  = run_en_c;
            decode_en_o = run_en_c;
            if (halt_req_i) state_d = HALTED;
         end
         HALTED: begin
            halted_o = 1'b1;
            if (step_req_i)       state_d = STEP;
            else if (!halt_req_i) state_d = RUN;
         end
         STEP: begin
            fetch_en_o  = run_en_c;
            decode_en_o = run_en_c;
            if (run_en_c) state_d = HALTED;
         end
         default: state_d = RUN;
      endcase

      if (kill_q) begin
         fetch_en_o  = 1'b1;
         decode_en_o = 1'b0;
         halted_o    = 1'b0;
      end

      // Enables stay low for as long as reset is held.
      if (rst) begin
         fetch_en_o  = 1'b0;
         decode_en_o = 1'b0;
         halted_o    = 1'b0;
      end
   end

   // Branch kill is only armed by an instruction that actually decoded.
   always_comb begin
      kill_d = branch_taken_i && decode_en_o;
   end

   // Saturating hazard-stall counter; clear wins over increment.
   always_comb begin
      stall_d = stall_q;
      if (perf_clr_i)
         stall_d = '0;
      else if (hazard_c && !kill_q && (state_q != HALTED) && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + CNT_W'(1);
   end

   assign id_kill_o      = kill_q;
   assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_mips16_pipeline_ctrl.sv
// Scoreboard bench for mips16_pipeline_ctrl: stimulus pushes the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_mips16_pipeline_ctrl;

   typedef struct packed {
      logic        f;
      logic        d;
      logic        k;
      logic        h;
      logic [15:0] s;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  dec_src1, dec_src2, ex_dest, mem_dest, wb_dest;
   logic        ex_wb_en, mem_wb_en, wb_wb_en;
   logic        branch_taken, halt_req, step_req, perf_clr;
   logic        fetch_en, decode_en, id_kill, halted;
   logic [15:0] stall_cycles;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   mips16_pipeline_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .dec_src1_i     (dec_src1),
      .dec_src2_i     (dec_src2),
      .ex_wb_en_i     (ex_wb_en),
      .mem_wb_en_i    (mem_wb_en),
      .wb_wb_en_i     (wb_wb_en),
      .ex_dest_i      (ex_dest),
      .mem_dest_i     (mem_dest),
      .wb_dest_i      (wb_dest),
      .branch_taken_i (branch_taken),
      .halt_req_i     (halt_req),
      .step_req_i     (step_req),
      .perf_clr_i     (perf_clr),
      .fetch_en_o     (fetch_en),
      .decode_en_o    (decode_en),
      .id_kill_o      (id_kill),
      .halted_o       (halted),
      .stall_cycles_o (stall_cycles)
   );

   // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
   always @(negedge clk) begin
      exp_t  e;
      exp_t  g;
      string n;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         g = '{f: fetch_en, d: decode_en, k: id_kill, h: halted, s: stall_cycles};
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL %s: got f=%b d=%b k=%b h=%b s=%h, want f=%b d=%b k=%b h=%b s=%h",
                     n, g.f, g.d, g.k, g.h, g.s, e.f, e.d, e.k, e.h, e.s);
         end
      end
   end

   task automatic clr_in();
      dec_src1 = 3'd0; dec_src2 = 3'd0;
      ex_wb_en = 1'b0; mem_wb_en = 1'b0; wb_wb_en = 1'b0;
      ex_dest = 3'd0; mem_dest = 3'd0; wb_dest = 3'd0;
      branch_taken = 1'b0; step_req = 1'b0; perf_clr = 1'b0;
   endtask

   task automatic set_haz();
      dec_src1 = 3'd3; ex_wb_en = 1'b1; ex_dest = 3'd3;
   endtask

   // Push the expectation for the current cycle, then advance to the next one.
   task automatic chk(input string n, input logic f, input logic d, input logic k,
                      input logic h, input logic [15:0] s);
      exp_q.push_back('{f: f, d: d, k: k, h: h, s: s});
      name_q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; halt_req = 1'b0;
      clr_in();
      @(posedge clk); #1;
      chk("reset0", 0, 0, 0, 0, 16'd0);
      chk("reset1", 0, 0, 0, 0, 16'd0);
      rst = 1'b0;
      chk("run_after_rst", 1, 1, 0, 0, 16'd0);

      dec_src1 = 3'd1; dec_src2 = 3'd2; ex_wb_en = 1'b1; ex_dest = 3'd3;
      chk("no_hazard", 1, 1, 0, 0, 16'd0);

      dec_src1 = 3'd3;
      chk("raw_ex_c1", 0, 0, 0, 0, 16'd0);
      chk("raw_ex_c2", 0, 0, 0, 0, 16'd1);
      ex_wb_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 3'd0;
      chk("mem_dest0", 1, 1, 0, 0, 16'd2);
      mem_dest = 3'd3;
      chk("raw_mem", 0, 0, 0, 0, 16'd2);
      clr_in(); dec_src1 = 3'd1; dec_src2 = 3'd5; wb_wb_en = 1'b1; wb_dest = 3'd5;
      chk("raw_wb_src2", 0, 0, 0, 0, 16'd3);
      wb_wb_en = 1'b0;
      chk("wb_en_off", 1, 1, 0, 0, 16'd4);
      clr_in(); ex_wb_en = 1'b1; ex_dest = 3'd0;
      chk("r0_no_haz", 1, 1, 0, 0, 16'd4);

      clr_in(); branch_taken = 1'b1;
      chk("br_cycle", 1, 1, 0, 0, 16'd4);
      clr_in(); set_haz();
      chk("kill_over_haz", 1, 0, 1, 0, 16'd4);
      chk("haz_after_kill", 0, 0, 0, 0, 16'd4);
      clr_in();
      chk("br_recover", 1, 1, 0, 0, 16'd5);
      set_haz(); branch_taken = 1'b1;
      chk("br_ignored_stall", 0, 0, 0, 0, 16'd5);
      clr_in();
      chk("no_kill", 1, 1, 0, 0, 16'd6);

      halt_req = 1'b1;
      chk("halt_req", 1, 1, 0, 0, 16'd6);
      chk("halted", 0, 0, 0, 1, 16'd6);
      set_haz();
      chk("halted_haz", 0, 0, 0, 1, 16'd6);
      clr_in();
      chk("halted2", 0, 0, 0, 1, 16'd6);
      step_req = 1'b1;
      chk("step_req", 0, 0, 0, 1, 16'd6);
      step_req = 1'b0;
      chk("step_dec", 1, 1, 0, 0, 16'd6);
      chk("step_back", 0, 0, 0, 1, 16'd6);

      set_haz(); step_req = 1'b1;
      chk("step_req_haz", 0, 0, 0, 1, 16'd6);
      step_req = 1'b0;
      chk("step_haz1", 0, 0, 0, 0, 16'd6);
      chk("step_haz2", 0, 0, 0, 0, 16'd7);
      chk("step_haz3", 0, 0, 0, 0, 16'd8);
      clr_in();
      chk("step_haz_dec", 1, 1, 0, 0, 16'd9);
      chk("step_haz_back", 0, 0, 0, 1, 16'd9);
      halt_req = 1'b0;
      chk("halt_drop", 0, 0, 0, 1, 16'd9);
      chk("resume_run", 1, 1, 0, 0, 16'd9);

      branch_taken = 1'b1; halt_req = 1'b1;
      chk("br_halt", 1, 1, 0, 0, 16'd9);
      branch_taken = 1'b0;
      chk("kill_before_halt", 1, 0, 1, 0, 16'd9);
      chk("halted_after_kill", 0, 0, 0, 1, 16'd9);
      halt_req = 1'b0;
      chk("halt_drop2", 0, 0, 0, 1, 16'd9);
      chk("run2", 1, 1, 0, 0, 16'd9);

      perf_clr = 1'b1;
      chk("perf_clr", 1, 1, 0, 0, 16'd9);
      perf_clr = 1'b0;
      chk("cleared", 1, 1, 0, 0, 16'd0);

      set_haz();
      repeat (70000) @(posedge clk);
      #1;
      chk("saturated", 0, 0, 0, 0, 16'hFFFF);
      perf_clr = 1'b1;
      chk("sat_clr", 0, 0, 0, 0, 16'hFFFF);
      clr_in();
      chk("sat_cleared", 1, 1, 0, 0, 16'd0);

      halt_req = 1'b1;
      chk("halt3", 1, 1, 0, 0, 16'd0);
      chk("halted3", 0, 0, 0, 1, 16'd0);
      set_haz(); step_req = 1'b1;
      chk("step3_req", 0, 0, 0, 1, 16'd0);
      step_req = 1'b0;
      chk("step3_haz", 0, 0, 0, 0, 16'd0);
      rst = 1'b1; halt_req = 1'b0; clr_in();
      chk("rst_mid_step", 0, 0, 0, 0, 16'd0);
      rst = 1'b0;
      chk("run_after_step_rst", 1, 1, 0, 0, 16'd0);

      branch_taken = 1'b1;
      chk("br4", 1, 1, 0, 0, 16'd0);
      branch_taken = 1'b0; rst = 1'b1;
      chk("rst_mid_kill", 0, 0, 0, 0, 16'd0);
      rst = 1'b0;
      chk("no_kill_after_rst", 1, 1, 0, 0, 16'd0);

      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
